// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared types and helpers for the cache-line memory responder.
// Rev 1.0
`default_nettype none

package line_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WORD_W      = 32;
    localparam int LINE_WORDS  = 4;
    localparam int OFFSET_BITS = $clog2(LINE_WORDS) + 2;

    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

    // Byte-offset bits covered by one line of the given word count.
    function automatic int offset_bits(input int words);
        return $clog2(words) + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_mem_responder_word_bram.sv
// word_bram: single-port, synchronous-read, write-first word memory.
// Rev 1.0
`default_nettype none

module word_bram #(
    parameter int ADDR_WIDTH = 14,
    parameter int WIDTH      = 32,
    parameter     INIT_FILE  = ""
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= din;
            dout      <= din;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/line_mem_responder.sv
// line_mem_responder: moves whole cache lines between the line interface and a word BRAM.
// Rev 1.0
`default_nettype none

module line_mem_responder
    import line_mem_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 14,
    parameter int LATENCY        = 2,
    parameter     INIT_FILE      = ""
) (
    input  logic                                     CLK,
    input  logic                                     RST_N,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic                                     req_we,
    input  logic [31:0]                              req_addr,
    input  logic [WORDS_PER_LINE-1:0][WORD_W-1:0]    wr_words,
    output logic                                     rsp_valid,
    output logic [WORDS_PER_LINE-1:0][WORD_W-1:0]    rd_words,
    output logic                                     busy
);

    localparam int IDX_W    = $clog2(WORDS_PER_LINE);
    localparam int OFF_BITS = offset_bits(WORDS_PER_LINE);
    localparam int BASE_W   = ADDR_WIDTH - IDX_W;
    localparam int CNT_MAX  = (LATENCY > WORDS_PER_LINE + 1) ? LATENCY : WORDS_PER_LINE + 1;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(WORDS_PER_LINE);

    state_t                                  state;
    state_t                                  state_nxt;
    logic [CNT_W-1:0]                        cnt;
    logic [CNT_W-1:0]                        cnt_m1;
    logic                                    we_q;
    logic [BASE_W-1:0]                       base;
    logic [WORDS_PER_LINE-1:0][WORD_W-1:0]   line_q;
    logic [IDX_W-1:0]                        beat_idx;
    logic [IDX_W-1:0]                        cap_idx;
    logic                                    accept;
    logic                                    mem_we;
    logic [ADDR_WIDTH-1:0]                   mem_addr;
    logic [WORD_W-1:0]                       mem_dout;
    logic                                    unused_bits;

    assign accept   = req_valid && req_ready;
    assign beat_idx = cnt[IDX_W-1:0];
    assign cnt_m1   = cnt - CNT_W'(1);
    assign cap_idx  = cnt_m1[IDX_W-1:0];
    assign mem_we   = (state == XFER) && we_q;
    assign mem_addr = {base, beat_idx};

    assign unused_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[OFF_BITS-1:0], cnt_m1[CNT_W-1:IDX_W]};

    word_bram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (WORD_W),
        .INIT_FILE  (INIT_FILE)
    ) u_bram (
        .CLK  (CLK),
        .we   (mem_we),
        .addr (mem_addr),
        .din  (line_q[beat_idx]),
        .dout (mem_dout)
    );

    // A read needs one extra XFER cycle to capture the last word out of the BRAM.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = (LATENCY == 0) ? XFER : WAIT;
            WAIT:    if (cnt == LAT_LAST) state_nxt = XFER;
            XFER:    if (cnt == (we_q ? WR_LAST : RD_LAST)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            base      <= '0;
            line_q    <= '0;
            rd_words  <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            rsp_valid <= (state_nxt == DONE);

            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state == WAIT || state == XFER) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (accept) begin
                we_q   <= req_we;
                base   <= req_addr[ADDR_WIDTH+1:OFF_BITS];
                line_q <= wr_words;
            end

            if (state == XFER && !we_q && cnt != '0) begin
                rd_words[cap_idx] <= mem_dout;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: scoreboard bench for a LATENCY=2 and a LATENCY=0 responder.
// Rev 1.0
`default_nettype none

module tb_line_mem_responder;

    typedef logic [3:0][31:0] tb_line_t;
    typedef struct {
        int       cyc;
        tb_line_t data;
    } txn_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic        sel       = 1'b0;
    logic [31:0] req_addr  = '0;
    tb_line_t    wr_words  = '0;

    logic     ready_a, rsp_a, busy_a, ready_b, rsp_b, busy_b;
    tb_line_t rd_a, rd_b;
    logic     valid_a, valid_b;
    logic     ready, rsp, busy;
    tb_line_t rd;

    int       checks = 0;
    int       errors = 0;
    txn_t     exp_q[$];
    txn_t     obs_q[$];
    logic [31:0] mem_m [int];
    tb_line_t last_rd [2];

    localparam tb_line_t L1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam tb_line_t L2 = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
    localparam tb_line_t L3 = {32'hA5A5A5A3, 32'h5A5A5A52, 32'hA5A5A5A1, 32'h5A5A5A50};
    localparam tb_line_t L5 = {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};
    localparam tb_line_t LA = {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000};
    localparam tb_line_t LB = {32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001, 32'hBBBB0000};
    localparam tb_line_t LC = {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000};
    localparam tb_line_t LE = {32'hEEEE0003, 32'hEEEE0002, 32'hEEEE0001, 32'hEEEE0000};

    assign valid_a = req_valid && !sel;
    assign valid_b = req_valid && sel;
    assign ready   = sel ? ready_b : ready_a;
    assign rsp     = sel ? rsp_b   : rsp_a;
    assign busy    = sel ? busy_b  : busy_a;
    assign rd      = sel ? rd_b    : rd_a;

    always #5 clk = ~clk;

    line_mem_responder #(.WORDS_PER_LINE(4), .ADDR_WIDTH(14), .LATENCY(2)) dut_a (
        .CLK(clk), .RST_N(rst_n), .req_valid(valid_a), .req_ready(ready_a), .req_we(req_we),
        .req_addr(req_addr), .wr_words(wr_words), .rsp_valid(rsp_a), .rd_words(rd_a), .busy(busy_a)
    );

    line_mem_responder #(.WORDS_PER_LINE(4), .ADDR_WIDTH(14), .LATENCY(0)) dut_b (
        .CLK(clk), .RST_N(rst_n), .req_valid(valid_b), .req_ready(ready_b), .req_we(req_we),
        .req_addr(req_addr), .wr_words(wr_words), .rsp_valid(rsp_b), .rd_words(rd_b), .busy(busy_b)
    );

    function automatic int waddr(input logic [31:0] addr, input int i);
        return int'((addr >> 4) & 32'h0000_0FFF) * 4 + i;
    endfunction

    // Reference model: updates the word store and pushes the expected response.
    task automatic expect_txn(input bit s, input bit we, input logic [31:0] addr, input tb_line_t w);
        txn_t e;
        for (int i = 0; i < 4; i++) begin
            if (we) mem_m[int'(s) * 16384 + waddr(addr, i)] = w[i];
            else    last_rd[s][i] = mem_m[int'(s) * 16384 + waddr(addr, i)];
        end
        e.data = last_rd[s];
        e.cyc  = (s ? 0 : 2) + 4 + (we ? 1 : 2);
        exp_q.push_back(e);
    endtask

    task automatic run_req(input bit s, input bit we, input logic [31:0] addr, input tb_line_t w,
                           input bit scramble);
        txn_t o;
        int   n;
        sel = s; req_we = we; req_addr = addr; wr_words = w; req_valid = 1'b1;
        n = 0;
        while (!ready && n < 20) begin @(posedge clk); #1; n++; end
        o.cyc = -1;
        if (ready) begin
            expect_txn(s, we, addr, w);
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (scramble) begin
                req_addr = addr ^ 32'h0000_0700;
                wr_words = ~w;
            end
            n = 1;
            while (!rsp && n < 40) begin @(posedge clk); #1; n++; end
            if (rsp) o.cyc = n;
        end else begin
            req_valid = 1'b0;
            o.cyc = -1;
            o.data = '0;
            exp_q.push_back(o);
        end
        o.data = rd;
        obs_q.push_back(o);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready_a, busy_a, rsp_a} !== 3'b100) begin
            errors++; $display("FAIL reset_ctrl_a: got %b want 100", {ready_a, busy_a, rsp_a});
        end
        checks++;
        if ({ready_b, busy_b, rsp_b} !== 3'b100) begin
            errors++; $display("FAIL reset_ctrl_b: got %b want 100", {ready_b, busy_b, rsp_b});
        end
        checks++;
        if (rd_a !== '0) begin errors++; $display("FAIL reset_rd_a: got %h want 0", rd_a); end
        checks++;
        if (rd_b !== '0) begin errors++; $display("FAIL reset_rd_b: got %h want 0", rd_b); end
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        run_req(0, 1, 32'h0000_0100, L1, 0);
        run_req(0, 0, 32'h0000_010C, '0, 0);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc) begin errors++; $display("FAIL wr_rd_cycle: got %0d want %0d", o.cyc, e.cyc); end
            checks++;
            if (o.data !== e.data) begin errors++; $display("FAIL wr_rd_data: got %h want %h", o.data, e.data); end
        end
    endtask

    task automatic test_busy;
        int   n;
        int   acc;
        txn_t e, o;
        sel = 0; req_we = 0; req_addr = 32'h0000_0104; wr_words = '0; req_valid = 1'b1;
        n = 0;
        while (!ready && n < 20) begin @(posedge clk); #1; n++; end
        expect_txn(0, 0, 32'h0000_0104, '0);
        @(posedge clk); #1;
        req_we = 1; req_addr = 32'h0000_0500; wr_words = L5;
        acc = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) begin
                checks++;
                if (ready !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL busy_hold c%0d: ready=%b busy=%b want 0/1", c, ready, busy);
                end
            end
            if (c < 8) begin
                checks++;
                if (rsp !== 1'b0) begin errors++; $display("FAIL busy_early_rsp c%0d: got %b want 0", c, rsp); end
            end
            if (c == 8) begin
                e = exp_q.pop_front();
                checks++;
                if (rsp !== 1'b1) begin errors++; $display("FAIL busy_rsp c8: got %b want 1", rsp); end
                checks++;
                if (rd !== e.data) begin errors++; $display("FAIL busy_rd_data: got %h want %h", rd, e.data); end
            end
            if (c == 9) begin
                checks++;
                if (ready !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL busy_idle c9: ready=%b busy=%b want 1/0", ready, busy);
                end
            end
            if (ready && req_valid) acc++;
            if (c < 9) begin @(posedge clk); #1; end
        end
        checks++;
        if (acc !== 1) begin errors++; $display("FAIL busy_accepts: got %0d want 1", acc); end
        expect_txn(0, 1, 32'h0000_0500, L5);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_second_accept: got %b want 1", busy); end
        n = 1;
        while (!rsp && n < 40) begin @(posedge clk); #1; n++; end
        o.cyc  = rsp ? n : -1;
        o.data = rd;
        obs_q.push_back(o);
        run_req(0, 0, 32'h0000_0508, '0, 0);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc) begin errors++; $display("FAIL b2b_cycle: got %0d want %0d", o.cyc, e.cyc); end
            checks++;
            if (o.data !== e.data) begin errors++; $display("FAIL b2b_data: got %h want %h", o.data, e.data); end
        end
    endtask

    task automatic test_latency0;
        run_req(1, 1, 32'h0000_0040, L2, 0);
        run_req(1, 0, 32'h0000_0048, '0, 0);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc) begin errors++; $display("FAIL lat0_cycle: got %0d want %0d", o.cyc, e.cyc); end
            checks++;
            if (o.data !== e.data) begin errors++; $display("FAIL lat0_data: got %h want %h", o.data, e.data); end
        end
    endtask

    task automatic test_addr_wrap;
        run_req(0, 1, 32'h0001_0000, L3, 0);
        run_req(0, 0, 32'h0000_0000, '0, 0);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc) begin errors++; $display("FAIL wrap_cycle: got %0d want %0d", o.cyc, e.cyc); end
            checks++;
            if (o.data !== e.data) begin errors++; $display("FAIL wrap_data: got %h want %h", o.data, e.data); end
        end
    endtask

    task automatic test_reset_mid_write;
        int n;
        int seen;
        run_req(0, 1, 32'h0000_0200, LA, 0);
        sel = 0; req_we = 1; req_addr = 32'h0000_0200; wr_words = LB; req_valid = 1'b1;
        n = 0;
        while (!ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ready_a, busy_a, rsp_a} !== 3'b100) begin
            errors++; $display("FAIL midrst_ctrl: got %b want 100", {ready_a, busy_a, rsp_a});
        end
        checks++;
        if (rd_a !== '0) begin errors++; $display("FAIL midrst_rd: got %h want 0", rd_a); end
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (rsp_a) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midrst_rsp: got %0d pulses want 0", seen); end
        mem_m[waddr(32'h0000_0200, 0)] = LB[0];
        mem_m[waddr(32'h0000_0200, 1)] = LB[1];
        last_rd[0] = '0;
        last_rd[1] = '0;
        run_req(0, 0, 32'h0000_0200, '0, 0);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc) begin errors++; $display("FAIL midrst_cycle: got %0d want %0d", o.cyc, e.cyc); end
            checks++;
            if (o.data !== e.data) begin errors++; $display("FAIL midrst_data: got %h want %h", o.data, e.data); end
        end
    endtask

    task automatic test_snapshot;
        run_req(0, 1, 32'h0000_0400, LE, 0);
        run_req(0, 1, 32'h0000_0300, LC, 1);
        run_req(0, 0, 32'h0000_0300, '0, 0);
        run_req(0, 0, 32'h0000_0400, '0, 0);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            txn_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc) begin errors++; $display("FAIL snap_cycle: got %0d want %0d", o.cyc, e.cyc); end
            checks++;
            if (o.data !== e.data) begin errors++; $display("FAIL snap_data: got %h want %h", o.data, e.data); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_busy();
        test_latency0();
        test_addr_wrap();
        test_reset_mid_write();
        test_snapshot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
